// File: rtl/apa_string_rx_if.sv
// Serial input and decoded pixel bus of the LED-string receiver.
// Latency: none, wires only.
// Backpressure: none; the pixel stream cannot be stalled.
interface apa_string_rx_if #(
  parameter int INDEX_W = 8
);
  logic               sck;
  logic               mosi;
  logic               pixel_valid;
  logic [INDEX_W-1:0] pixel_index;
  logic [4:0]         brightness;
  logic [7:0]         blue_out;
  logic [7:0]         green_out;
  logic [7:0]         red_out;
  logic               frame_start;
  logic               frame_done;
  logic               frame_error;
  logic               busy;

  modport master (
    output sck, mosi,
    input  pixel_valid, pixel_index, brightness, blue_out, green_out, red_out,
    input  frame_start, frame_done, frame_error, busy
  );

  modport slave (
    input  sck, mosi,
    output pixel_valid, pixel_index, brightness, blue_out, green_out, red_out,
    output frame_start, frame_done, frame_error, busy
  );
endinterface

// File: rtl/apa_string_rx.sv
// APA102-style string receiver: oversamples sck/mosi, deframes 32-bit words, decodes pixels.
// Latency: strobes 4 CLK after the first CLK edge that samples the sck edge of the 32nd bit.
// Backpressure: none; every strobe is a single CLK and fields hold until the next pixel.
module apa_string_rx #(
  parameter int STRING_SIZE  = 30,
  parameter int IDLE_TIMEOUT = 4096,
  parameter int INDEX_W      = 8
) (
  input logic           CLK,
  input logic           RST,
  apa_string_rx_if.slave bus
);

  localparam int                 IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0]  IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [INDEX_W-1:0] LAST_PIX = INDEX_W'(STRING_SIZE - 1);
  localparam logic [5:0]         ZR_FULL  = 6'd32;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    PIXEL = 2'd1,
    TAIL  = 2'd2
  } state_t;

  // sck chain resets high so a line held high through reset never looks like a rise
  logic sck_m, sck_s, sck_d;
  logic mosi_m, mosi_s, mosi_d;
  logic rise;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sck_m  <= 1'b1;
      sck_s  <= 1'b1;
      sck_d  <= 1'b1;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
      mosi_d <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sck_m  <= bus.sck;
      sck_s  <= sck_m;
      sck_d  <= sck_s;
      mosi_m <= bus.mosi;
      mosi_s <= mosi_m;
      mosi_d <= mosi_s;
      rise   <= sck_s & ~sck_d;
    end
  end

  logic [31:0]       sr;
  logic              bit_vld;
  logic [IDLE_W-1:0] idle_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr       <= '0;
      bit_vld  <= 1'b0;
      idle_cnt <= '0;
    end else begin
      bit_vld <= rise;
      if (rise) begin
        sr       <= {sr[30:0], mosi_d};
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end

  state_t             state, state_n;
  logic [4:0]         bit_cnt, bit_cnt_n;
  logic [5:0]         zero_run, zero_run_n;
  logic [INDEX_W-1:0] pix_cnt, pix_cnt_n;
  logic [INDEX_W-1:0] idx_q, idx_n;
  logic [28:0]        pix_q, pix_n;
  logic               pv_q, pv_n;
  logic               fs_q, fs_n;
  logic               fd_q, fd_n;
  logic               fe_q, fe_n;
  logic               busy_q;

  logic       new_bit;
  logic       start_hit;
  logic       skip_bit;
  logic [5:0] zr_inc;

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    zero_run_n = zero_run;
    pix_cnt_n  = pix_cnt;
    idx_n      = idx_q;
    pix_n      = pix_q;
    pv_n       = 1'b0;
    fs_n       = 1'b0;
    fd_n       = 1'b0;
    fe_n       = 1'b0;

    new_bit   = sr[0];
    zr_inc    = new_bit ? 6'd0 : ((zero_run == ZR_FULL) ? ZR_FULL : zero_run + 6'd1);
    start_hit = ~new_bit && (zero_run == 6'd31);
    // zeros past an unbroken 32-zero run only stretch the start frame; they never open a word
    skip_bit  = (bit_cnt == 5'd0) && ~new_bit && (zero_run == ZR_FULL);

    if (bit_vld) begin
      zero_run_n = zr_inc;
      case (state)
        HUNT, TAIL: begin
          if (start_hit) begin
            fs_n      = 1'b1;
            state_n   = PIXEL;
            bit_cnt_n = 5'd0;
            pix_cnt_n = '0;
          end
        end
        PIXEL: begin
          if (!skip_bit) begin
            if (bit_cnt != 5'd31) begin
              bit_cnt_n = bit_cnt + 5'd1;
            end else begin
              bit_cnt_n = 5'd0;
              if (sr[31:29] == 3'b111) begin
                pv_n      = 1'b1;
                idx_n     = pix_cnt;
                pix_n     = sr[28:0];
                pix_cnt_n = pix_cnt + INDEX_W'(1);
                if (pix_cnt == LAST_PIX) begin
                  fd_n    = 1'b1;
                  state_n = TAIL;
                end
              end else if (sr == 32'd0) begin
                fs_n      = 1'b1;
                pix_cnt_n = '0;
              end else begin
                fe_n       = 1'b1;
                state_n    = HUNT;
                zero_run_n = 6'd0;
              end
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end else if (state == PIXEL && bit_cnt != 5'd0 && idle_cnt == IDLE_MAX) begin
      fe_n       = 1'b1;
      state_n    = HUNT;
      bit_cnt_n  = 5'd0;
      zero_run_n = 6'd0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= HUNT;
      bit_cnt  <= 5'd0;
      zero_run <= 6'd0;
      pix_cnt  <= '0;
      idx_q    <= '0;
      pix_q    <= '0;
      pv_q     <= 1'b0;
      fs_q     <= 1'b0;
      fd_q     <= 1'b0;
      fe_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      zero_run <= zero_run_n;
      pix_cnt  <= pix_cnt_n;
      idx_q    <= idx_n;
      pix_q    <= pix_n;
      pv_q     <= pv_n;
      fs_q     <= fs_n;
      fd_q     <= fd_n;
      fe_q     <= fe_n;
      busy_q   <= (state == PIXEL);
    end
  end

  assign bus.pixel_valid = pv_q;
  assign bus.pixel_index = idx_q;
  assign bus.brightness  = pix_q[28:24];
  assign bus.blue_out    = pix_q[23:16];
  assign bus.green_out   = pix_q[15:8];
  assign bus.red_out     = pix_q[7:0];
  assign bus.frame_start = fs_q;
  assign bus.frame_done  = fd_q;
  assign bus.frame_error = fe_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_apa_string_rx.sv
// Bench for apa_string_rx: bit-serial stimulus, event capture, table vectors and a stream-level model.
// Stream items: 0/1 data bit, 2 long sck gap, 3 reset pulse.
module tb_apa_string_rx;
  localparam int STRING_SIZE  = 30;
  localparam int IDLE_TIMEOUT = 4096;
  localparam int INDEX_W      = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  apa_string_rx_if #(.INDEX_W(INDEX_W)) bus ();

  apa_string_rx #(
    .STRING_SIZE (STRING_SIZE),
    .IDLE_TIMEOUT(IDLE_TIMEOUT),
    .INDEX_W     (INDEX_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // kind: 1 frame_start, 2 pixel, 3 frame_error
  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] word;
    bit          done;
  } ev_t;

  ev_t got[$];
  ev_t exp_q[$];
  int  stim[$];

  function automatic ev_t mk_ev(input int kind, input int idx, input logic [31:0] word, input bit done);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.word = word;
    e.done = done;
    return e;
  endfunction

  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.frame_start) got.push_back(mk_ev(1, 0, 32'd0, 1'b0));
      if (bus.pixel_valid)
        got.push_back(mk_ev(2, int'(bus.pixel_index),
                            {3'b111, bus.brightness, bus.blue_out, bus.green_out, bus.red_out},
                            bus.frame_done));
      if (bus.frame_done) chk("done_needs_pixel", bus.pixel_valid, 1'b1);
      if (bus.frame_error) begin
        chk("error_vs_pixel", bus.pixel_valid, 1'b0);
        got.push_back(mk_ev(3, 0, 32'd0, 1'b0));
      end
    end
  end

  // Stream-level reference: 0 hunting, 1 in a string, 2 end-frame filler
  int          m_st = 0;
  int          m_zr = 0;
  int          m_bc = 0;
  int          m_pc = 0;
  logic [31:0] m_w  = '0;

  task automatic model_item(input int it);
    int pz;
    bit b;
    if (it == 3) begin
      m_st = 0; m_zr = 0; m_bc = 0; m_pc = 0; m_w = '0;
    end else if (it == 2) begin
      if (m_st == 1 && m_bc != 0) begin
        exp_q.push_back(mk_ev(3, 0, 32'd0, 1'b0));
        m_st = 0; m_zr = 0; m_bc = 0;
      end
    end else begin
      b    = (it == 1);
      pz   = m_zr;
      m_zr = b ? 0 : ((pz < 32) ? pz + 1 : 32);
      if (m_st != 1) begin
        if (!b && pz == 31) begin
          exp_q.push_back(mk_ev(1, 0, 32'd0, 1'b0));
          m_st = 1; m_bc = 0; m_pc = 0;
        end
      end else if (!(m_bc == 0 && !b && pz >= 32)) begin
        m_w = {m_w[30:0], b};
        m_bc++;
        if (m_bc == 32) begin
          m_bc = 0;
          if (m_w[31:29] == 3'b111) begin
            exp_q.push_back(mk_ev(2, m_pc, m_w, m_pc == STRING_SIZE - 1));
            if (m_pc == STRING_SIZE - 1) m_st = 2;
            m_pc++;
          end else if (m_w == 32'd0) begin
            exp_q.push_back(mk_ev(1, 0, 32'd0, 1'b0));
            m_pc = 0;
          end else begin
            exp_q.push_back(mk_ev(3, 0, 32'd0, 1'b0));
            m_st = 0; m_zr = 0;
          end
        end
      end
    end
  endtask

  task automatic send_bit(input bit b);
    bus.mosi = b;
    bus.sck  = 1'b0;
    repeat (3) @(posedge CLK);
    #1 bus.sck = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic idle_gap();
    int n0;
    repeat (8) @(posedge CLK);
    n0 = got.size();
    repeat (IDLE_TIMEOUT - 28) @(posedge CLK);
    chk("gap_no_early_event", got.size(), n0);
    repeat (30) @(posedge CLK);
    #1;
  endtask

  task automatic pulse_rst();
    @(posedge CLK);
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_outputs_zero",
        {bus.pixel_valid, bus.pixel_index, bus.brightness, bus.blue_out, bus.green_out,
         bus.red_out, bus.frame_start, bus.frame_done, bus.frame_error, bus.busy}, 64'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic run_stim();
    foreach (stim[i]) begin
      model_item(stim[i]);
      case (stim[i])
        0, 1:    send_bit(stim[i] == 1);
        2:       idle_gap();
        default: pulse_rst();
      endcase
    end
    repeat (10) @(posedge CLK);
    #1;
    stim.delete();
  endtask

  task automatic check_events(input string name);
    int n;
    chk({name, "_count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_kind%0d", name, i), got[i].kind, exp_q[i].kind);
      if (exp_q[i].kind == 2) begin
        chk($sformatf("%s_idx%0d", name, i), got[i].idx, exp_q[i].idx);
        chk($sformatf("%s_word%0d", name, i), got[i].word, exp_q[i].word);
        chk($sformatf("%s_done%0d", name, i), got[i].done, exp_q[i].done);
      end
    end
    chk({name, "_busy_end"}, bus.busy, m_st == 1);
    got.delete();
    exp_q.delete();
  endtask

  task automatic push_bits(input logic [31:0] w, input int n);
    for (int i = 31; i > 31 - n; i--) stim.push_back(w[i] ? 1 : 0);
  endtask

  task automatic push_run(input int v, input int n);
    for (int i = 0; i < n; i++) stim.push_back(v);
  endtask

  function automatic logic [31:0] rand_pix();
    logic [31:0] r;
    r        = $urandom;
    r[31:29] = 3'b111;
    return r;
  endfunction

  typedef struct {
    logic [31:0] word;
    int          kind;
    int          idx;
    logic [4:0]  bri;
    logic [7:0]  b;
    logic [7:0]  g;
    logic [7:0]  r;
  } vec_t;

  vec_t tbl[7];
  logic fs_seen[6];

  initial begin
    tbl[0] = '{32'hFFFF0000, 2, 0, 5'h1F, 8'hFF, 8'h00, 8'h00};
    tbl[1] = '{32'hFFFFFFFF, 2, 1, 5'h1F, 8'hFF, 8'hFF, 8'hFF};
    tbl[2] = '{32'hE0000000, 2, 2, 5'h00, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{32'hE1A2B3C4, 2, 3, 5'h01, 8'hA2, 8'hB3, 8'hC4};
    tbl[4] = '{32'h00000000, 1, 0, 5'h00, 8'h00, 8'h00, 8'h00};
    tbl[5] = '{32'hF5123456, 2, 0, 5'h15, 8'h12, 8'h34, 8'h56};
    tbl[6] = '{32'h4A123456, 3, 0, 5'h00, 8'h00, 8'h00, 8'h00};

    bus.sck  = 1'b0;
    bus.mosi = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_state",
        {bus.pixel_valid, bus.pixel_index, bus.brightness, bus.blue_out, bus.green_out,
         bus.red_out, bus.frame_start, bus.frame_done, bus.frame_error, bus.busy}, 64'd0);
    @(posedge CLK);
    #1 RST = 1'b0;

    // strobe timing relative to the first CLK edge that sees the 32nd sck rise
    for (int i = 0; i < 31; i++) send_bit(1'b0);
    bus.mosi = 1'b0;
    bus.sck  = 1'b0;
    repeat (3) @(posedge CLK);
    #1 bus.sck = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      fs_seen[k] = bus.frame_start;
    end
    chk("latency_edge3", fs_seen[3], 1'b0);
    chk("latency_edge4", fs_seen[4], 1'b1);
    chk("latency_edge5", fs_seen[5], 1'b0);
    chk("busy_after_start", bus.busy, 1'b1);
    got.delete();

    // table vectors
    stim.push_back(3);
    push_run(0, 32);
    foreach (tbl[i]) push_bits(tbl[i].word, 32);
    run_stim();
    chk("tbl_count", got.size(), 8);
    if (got.size() == 8) begin
      chk("tbl_start", got[0].kind, 1);
      foreach (tbl[i]) begin
        chk($sformatf("tbl_kind%0d", i), got[i+1].kind, tbl[i].kind);
        if (tbl[i].kind == 2) begin
          chk($sformatf("tbl_idx%0d", i), got[i+1].idx, tbl[i].idx);
          chk($sformatf("tbl_bri%0d", i), got[i+1].word[28:24], tbl[i].bri);
          chk($sformatf("tbl_blue%0d", i), got[i+1].word[23:16], tbl[i].b);
          chk($sformatf("tbl_green%0d", i), got[i+1].word[15:8], tbl[i].g);
          chk($sformatf("tbl_red%0d", i), got[i+1].word[7:0], tbl[i].r);
          chk($sformatf("tbl_done%0d", i), got[i+1].done, 1'b0);
        end
      end
    end
    check_events("table");

    // full string of blue pixels
    push_run(0, 32);
    for (int i = 0; i < STRING_SIZE; i++) push_bits(32'hFFFF0000, 32);
    push_run(1, 32);
    run_stim();
    check_events("string_basic");

    // all-ones pixel mid-string, 45-bit end frame
    push_run(0, 32);
    for (int i = 0; i < STRING_SIZE; i++) push_bits((i == 5) ? 32'hFFFFFFFF : rand_pix(), 32);
    push_run(1, 45);
    run_stim();
    check_events("white_pixel");

    // bad header then resync
    push_run(0, 32);
    for (int i = 0; i < 4; i++) push_bits(rand_pix(), 32);
    push_bits(32'h4A123456, 32);
    push_run(0, 32);
    for (int i = 0; i < 3; i++) push_bits(rand_pix(), 32);
    run_stim();
    check_events("bad_header");

    // long start frame
    stim.push_back(3);
    push_run(0, 40);
    for (int i = 0; i < 3; i++) push_bits(rand_pix(), 32);
    run_stim();
    check_events("long_start");

    // idle mid-word times out, idle at a word boundary is harmless
    stim.push_back(3);
    push_run(0, 32);
    for (int i = 0; i < 7; i++) push_bits(rand_pix(), 32);
    push_bits(rand_pix(), 17);
    stim.push_back(2);
    push_run(0, 32);
    for (int i = 0; i < 3; i++) push_bits(rand_pix(), 32);
    stim.push_back(2);
    for (int i = 0; i < 2; i++) push_bits(rand_pix(), 32);
    push_run(1, 40);
    run_stim();
    check_events("idle_timeout");

    // back-to-back strings, reset mid-pixel, clean string after
    push_run(0, 32);
    for (int i = 0; i < STRING_SIZE; i++) push_bits(rand_pix(), 32);
    push_run(1, 45);
    for (int s = 0; s < 2; s++) begin
      push_run(0, 32);
      for (int i = 0; i < ((s == 0) ? STRING_SIZE : 12); i++) push_bits(rand_pix(), 32);
    end
    push_bits(rand_pix(), 10);
    stim.push_back(3);
    push_run(0, 32);
    for (int i = 0; i < STRING_SIZE; i++) push_bits(rand_pix(), 32);
    push_run(1, 32);
    run_stim();
    check_events("multi_string");

    // randomized mix of pixels, zero words, garbage, runs and gaps
    begin
      int gaps = 0;
      int r;
      push_run(0, 32);
      for (int i = 0; i < 40; i++) begin
        r = $urandom_range(0, 19);
        if (r < 12 || (r == 19 && gaps >= 2)) push_bits(rand_pix(), 32);
        else if (r < 14) push_bits(32'd0, 32);
        else if (r < 16) push_bits($urandom, 32);
        else if (r < 18) push_run(0, $urandom_range(1, 40));
        else if (r == 18) push_run(1, $urandom_range(1, 40));
        else begin
          stim.push_back(2);
          gaps++;
        end
      end
      run_stim();
      check_events("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
